// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer.
// State codes, opcodes, datapath select encodings and the control vector.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
`ifdef MC_ILLEGAL_TRAP_EN
        , ST_TRAP   = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
`ifdef MC_ILLEGAL_TRAP_EN
        logic       illegal_op;
`endif
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE, OP_ADDI, OP_ANDI, OP_BEQ,
            OP_BNE, OP_LW, OP_SW, OP_J: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> datapath control vector for the sequencer.
// Under MC_ILLEGAL_TRAP_EN the TRAP state raises illegal_op.
module mc_output_decode
    import mc_pkg::*;
(
    input  logic   rst_i,
    input  state_t state_i,
    input  logic   rdy_i,
    input  logic   andi_i,
    input  logic   bne_i,
`ifndef MC_ILLEGAL_TRAP_EN
    input  logic   nop_i,
`endif
    output ctrl_t  ctrl_o
);

    // Moore decode with mem_ready gating in the memory states; reset forces zero.
    always_comb begin
        ctrl_o = '0;
        if (!rst_i) begin
            unique case (state_i)
                ST_FETCH: begin
                    ctrl_o.mem_read  = 1'b1;
                    ctrl_o.alu_src_b = SRCB_FOUR;
                    ctrl_o.alu_op    = ALU_ADD;
                    ctrl_o.pc_source = PCSRC_ALU;
                    ctrl_o.pc_write  = rdy_i;
                    ctrl_o.ir_write  = rdy_i;
                end
                ST_DECODE: begin
                    ctrl_o.alu_src_b = SRCB_IMM_SH;
`ifndef MC_ILLEGAL_TRAP_EN
                    ctrl_o.instr_done = nop_i;
`endif
                end
                ST_MEM_ADDR: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_IMM;
                end
                ST_MEM_RD: begin
                    ctrl_o.mem_read = 1'b1;
                    ctrl_o.iord     = 1'b1;
                end
                ST_MEM_WB: begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.instr_done = 1'b1;
                end
                ST_MEM_WR: begin
                    ctrl_o.mem_write  = 1'b1;
                    ctrl_o.iord       = 1'b1;
                    ctrl_o.instr_done = rdy_i;
                end
                ST_EXEC_R: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_REG;
                    ctrl_o.alu_op    = ALU_FUNCT;
                end
                ST_R_WB: begin
                    ctrl_o.reg_dst    = 1'b1;
                    ctrl_o.mem_to_reg = 1'b1;
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.instr_done = 1'b1;
                end
                ST_EXEC_I: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_IMM;
                    ctrl_o.alu_op    = andi_i ? ALU_AND : ALU_ADD;
                end
                ST_I_WB: begin
                    ctrl_o.mem_to_reg = 1'b1;
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.instr_done = 1'b1;
                end
                ST_BRANCH: begin
                    ctrl_o.alu_src_a        = 1'b1;
                    ctrl_o.alu_src_b        = SRCB_REG;
                    ctrl_o.alu_op           = ALU_SUB;
                    ctrl_o.pc_source        = PCSRC_ALUOUT;
                    ctrl_o.pc_write_cond    = !bne_i;
                    ctrl_o.pc_write_cond_ne = bne_i;
                    ctrl_o.instr_done       = 1'b1;
                end
                ST_JUMP: begin
                    ctrl_o.pc_source  = PCSRC_JUMP;
                    ctrl_o.pc_write   = 1'b1;
                    ctrl_o.instr_done = 1'b1;
                end
`ifdef MC_ILLEGAL_TRAP_EN
                ST_TRAP: begin
                    ctrl_o.illegal_op = 1'b1;
                end
`endif
                default: ctrl_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS sequencer: state register, next-state and DECODE flags.
// Build option MC_ILLEGAL_TRAP_EN adds the TRAP state and illegal_op port.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int MEM_WAIT_EN = 1,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               PCWriteCondNe,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               instr_done,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic               illegal_op,
`endif
    output logic [STATE_W-1:0] state_dbg
);

    state_t state_q;
    logic   lw_q;
    logic   andi_q;
    logic   bne_q;
    logic   rdy;
    ctrl_t  ctrl;

    assign rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

`ifndef MC_ILLEGAL_TRAP_EN
    logic nop;
    assign nop = !op_is_legal(opcode);
`endif

    // State walk; opcode class flags are captured only while in DECODE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            lw_q    <= 1'b0;
            andi_q  <= 1'b0;
            bne_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (rdy) state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    lw_q   <= (opcode == OP_LW);
                    andi_q <= (opcode == OP_ANDI);
                    bne_q  <= (opcode == OP_BNE);
                    case (opcode)
                        OP_RTYPE:        state_q <= ST_EXEC_R;
                        OP_ADDI, OP_ANDI: state_q <= ST_EXEC_I;
                        OP_LW, OP_SW:    state_q <= ST_MEM_ADDR;
                        OP_BEQ, OP_BNE:  state_q <= ST_BRANCH;
                        OP_J:            state_q <= ST_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
                        default:         state_q <= ST_TRAP;
`else
                        default:         state_q <= ST_FETCH;
`endif
                    endcase
                end
                ST_MEM_ADDR: state_q <= lw_q ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD: begin
                    if (rdy) state_q <= ST_MEM_WB;
                end
                ST_MEM_WR: begin
                    if (rdy) state_q <= ST_FETCH;
                end
                ST_EXEC_R: state_q <= ST_R_WB;
                ST_EXEC_I: state_q <= ST_I_WB;
`ifdef MC_ILLEGAL_TRAP_EN
                ST_TRAP:   state_q <= ST_TRAP;
`endif
                default:   state_q <= ST_FETCH;
            endcase
        end
    end

    mc_output_decode u_dec (
        .rst_i   (reset),
        .state_i (state_q),
        .rdy_i   (rdy),
        .andi_i  (andi_q),
        .bne_i   (bne_q),
`ifndef MC_ILLEGAL_TRAP_EN
        .nop_i   (nop),
`endif
        .ctrl_o  (ctrl)
    );

    assign PCWrite       = ctrl.pc_write;
    assign PCWriteCond   = ctrl.pc_write_cond;
    assign PCWriteCondNe = ctrl.pc_write_cond_ne;
    assign IorD          = ctrl.iord;
    assign MemRead       = ctrl.mem_read;
    assign MemWrite      = ctrl.mem_write;
    assign IRWrite       = ctrl.ir_write;
    assign MemtoReg      = ctrl.mem_to_reg;
    assign RegDst        = ctrl.reg_dst;
    assign RegWrite      = ctrl.reg_write;
    assign ALUSrcA       = ctrl.alu_src_a;
    assign ALUSrcB       = ctrl.alu_src_b;
    assign ALUOp         = ctrl.alu_op;
    assign PCSource      = ctrl.pc_source;
    assign instr_done    = ctrl.instr_done;
`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_op    = ctrl.illegal_op;
`endif
    assign state_dbg     = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm.
// Define MC_ILLEGAL_TRAP_EN to exercise the TRAP path instead of the NOP path.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead;
    logic       MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       instr_done;
    logic [3:0] state_dbg;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif
    logic [17:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign outs = {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead,
                   MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                   ALUSrcB, ALUOp, PCSource, instr_done};

    mc_control_fsm #(.MEM_WAIT_EN(1), .STATE_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .PCWriteCond   (PCWriteCond),
        .PCWriteCondNe (PCWriteCondNe),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .MemtoReg      (MemtoReg),
        .RegDst        (RegDst),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUOp         (ALUOp),
        .PCSource      (PCSource),
        .instr_done    (instr_done),
`ifdef MC_ILLEGAL_TRAP_EN
        .illegal_op    (illegal_op),
`endif
        .state_dbg     (state_dbg)
    );

    task automatic test_reset;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (outs !== 18'h0) begin
            errors++;
            $display("FAIL reset_outs got %h want 0", outs);
        end
        checks++;
        if (state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got %0d want 0", state_dbg);
        end
        mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (MemRead !== 1'b1 || PCWrite !== 1'b0) begin
            errors++;
            $display("FAIL fetch_after_reset MemRead %b PCWrite %b want 1 0",
                     MemRead, PCWrite);
        end
        @(negedge clk);
    endtask

    task automatic test_lw;
        logic [3:0] es [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        int dones = 0;
        opcode = 6'b100011;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state_dbg !== es[i]) begin
                errors++;
                $display("FAIL lw_state c%0d got %0d want %0d", i, state_dbg, es[i]);
            end
            if (instr_done === 1'b1) dones++;
            if (i == 0) begin
                checks++;
                if ({MemRead, PCWrite, IRWrite, ALUSrcB} !== 5'b11101) begin
                    errors++;
                    $display("FAIL lw_fetch got %b want 11101",
                             {MemRead, PCWrite, IRWrite, ALUSrcB});
                end
            end
            if (i == 1) begin
                checks++;
                if (ALUSrcB !== 2'b11 || ALUSrcA !== 1'b0) begin
                    errors++;
                    $display("FAIL lw_decode ALUSrcB %b want 11", ALUSrcB);
                end
            end
            if (i == 3) begin
                checks++;
                if (MemRead !== 1'b1 || IorD !== 1'b1) begin
                    errors++;
                    $display("FAIL lw_memrd MemRead %b IorD %b want 1 1", MemRead, IorD);
                end
            end
            if (i == 4) begin
                checks++;
                if ({RegWrite, MemtoReg, RegDst, instr_done} !== 4'b1001) begin
                    errors++;
                    $display("FAIL lw_wb got %b want 1001",
                             {RegWrite, MemtoReg, RegDst, instr_done});
                end
            end
            @(negedge clk);
        end
        checks++;
        if (dones != 1 || state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL lw_done dones %0d state %0d want 1 0", dones, state_dbg);
        end
    endtask

    task automatic test_sw_stall;
        logic [3:0] es [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        logic       rd [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int mw = 0;
        int dones = 0;
        int dcyc = -1;
        opcode = 6'b101011;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rd[i];
            #1;
            checks++;
            if (state_dbg !== es[i]) begin
                errors++;
                $display("FAIL sw_state c%0d got %0d want %0d", i, state_dbg, es[i]);
            end
            if (MemWrite === 1'b1) mw++;
            if (instr_done === 1'b1) begin
                dones++;
                dcyc = i;
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        checks++;
        if (mw != 4) begin
            errors++;
            $display("FAIL sw_memwrite_cycles got %0d want 4", mw);
        end
        checks++;
        if (dones != 1 || dcyc != 6) begin
            errors++;
            $display("FAIL sw_done count %0d cycle %0d want 1 6", dones, dcyc);
        end
        checks++;
        if (state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL sw_end_state got %0d want 0", state_dbg);
        end
    endtask

    task automatic test_reset_mid_write;
        opcode = 6'b101011;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state_dbg !== 4'd5 || MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre state %0d MemWrite %b want 5 1", state_dbg, MemWrite);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (outs !== 18'h0 || state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL rst_async outs %h state %0d want 0 0", outs, state_dbg);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (state_dbg !== 4'd0 || MemWrite !== 1'b0) begin
                errors++;
                $display("FAIL rst_post c%0d state %0d MemWrite %b want 0 0",
                         i, state_dbg, MemWrite);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_branch;
        logic [5:0] ops [2] = '{6'b000100, 6'b000101};
        logic [1:0] cond [2] = '{2'b10, 2'b01};
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            mem_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                #1;
                if (i == 2) begin
                    checks++;
                    if (state_dbg !== 4'd10) begin
                        errors++;
                        $display("FAIL br%0d_state got %0d want 10", k, state_dbg);
                    end
                    checks++;
                    if ({PCWriteCond, PCWriteCondNe} !== cond[k]) begin
                        errors++;
                        $display("FAIL br%0d_cond got %b want %b", k,
                                 {PCWriteCond, PCWriteCondNe}, cond[k]);
                    end
                    checks++;
                    if ({ALUOp, PCSource, ALUSrcA, ALUSrcB, instr_done} !== 8'b01011001) begin
                        errors++;
                        $display("FAIL br%0d_ctl got %b want 01011001", k,
                                 {ALUOp, PCSource, ALUSrcA, ALUSrcB, instr_done});
                    end
                end
                @(negedge clk);
            end
            checks++;
            if (state_dbg !== 4'd0) begin
                errors++;
                $display("FAIL br%0d_len state %0d want 0", k, state_dbg);
            end
        end
    endtask

    task automatic test_r_andi;
        opcode = 6'b000000;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (state_dbg !== 4'd6 || {ALUOp, ALUSrcA, ALUSrcB} !== 5'b10100) begin
            errors++;
            $display("FAIL r_exec state %0d ctl %b want 6 10100",
                     state_dbg, {ALUOp, ALUSrcA, ALUSrcB});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({state_dbg, RegDst, MemtoReg, RegWrite, instr_done} !== 8'b0111_1111) begin
            errors++;
            $display("FAIL r_wb got %b want 01111111",
                     {state_dbg, RegDst, MemtoReg, RegWrite, instr_done});
        end
        @(negedge clk);
        opcode = 6'b001100;
        @(negedge clk);
        @(negedge clk);
        opcode = 6'b001000;
        #1;
        checks++;
        if (state_dbg !== 4'd8 || {ALUOp, ALUSrcA, ALUSrcB} !== 5'b11110) begin
            errors++;
            $display("FAIL andi_exec state %0d ctl %b want 8 11110",
                     state_dbg, {ALUOp, ALUSrcA, ALUSrcB});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({state_dbg, RegDst, MemtoReg, RegWrite, instr_done} !== 8'b1001_0111) begin
            errors++;
            $display("FAIL andi_wb got %b want 10010111",
                     {state_dbg, RegDst, MemtoReg, RegWrite, instr_done});
        end
        @(negedge clk);
    endtask

    task automatic test_jump;
        opcode = 6'b000010;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({state_dbg, PCWrite, PCSource, instr_done} !== 8'b1011_1101) begin
            errors++;
            $display("FAIL jump got %b want 10111101",
                     {state_dbg, PCWrite, PCSource, instr_done});
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL jump_len state %0d want 0", state_dbg);
        end
    endtask

    task automatic test_illegal;
        opcode = 6'b111111;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
`ifdef MC_ILLEGAL_TRAP_EN
        checks++;
        if (state_dbg !== 4'd1 || instr_done !== 1'b0 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL trap_decode state %0d done %b ill %b want 1 0 0",
                     state_dbg, instr_done, illegal_op);
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            opcode = (i % 2 == 0) ? 6'b000000 : 6'b100011;
            #1;
            checks++;
            if (state_dbg !== 4'd12 || illegal_op !== 1'b1 || outs !== 18'h0) begin
                errors++;
                $display("FAIL trap_hold c%0d state %0d ill %b outs %h want 12 1 0",
                         i, state_dbg, illegal_op, outs);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (state_dbg !== 4'd0 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL trap_exit state %0d ill %b want 0 0", state_dbg, illegal_op);
        end
        @(negedge clk);
`else
        checks++;
        if (state_dbg !== 4'd1 || instr_done !== 1'b1) begin
            errors++;
            $display("FAIL nop_decode state %0d done %b want 1 1", state_dbg, instr_done);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_dbg !== 4'd0 || instr_done !== 1'b0) begin
            errors++;
            $display("FAIL nop_len state %0d done %b want 0 0", state_dbg, instr_done);
        end
        @(negedge clk);
`endif
    endtask

    initial begin
        reset = 1'b1;
        opcode = 6'd0;
        mem_ready = 1'b0;
        @(negedge clk);
        test_reset;
        test_lw;
        test_sw_stall;
        test_reset_mid_write;
        test_branch;
        test_r_andi;
        test_jump;
        test_illegal;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle sequencing controller for the single-memory MIPS datapath variant. It supports the same ISA subset as the pipelined decoder: R-type (add/sub/and/or/slt), addi, andi, beq, bne, lw, sw and j. It walks each instruction through fetch, decode, execute, memory and writeback states, driving the datapath mux selects and write enables. It stalls on a memory ready handshake.

Parameters:
MEM_WAIT_EN, 1, when 1 the memory states hold until mem_ready=1; when 0 mem_ready is ignored and treated as constant 1.
STATE_W, 4, state register width; must be at least 4.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; forces the FETCH state.
opcode  in  6  IR[31:26]; sampled only in DECODE; stable from the end of FETCH.
mem_ready  in  1  memory has completed the current access this cycle.
PCWrite  out  1  unconditional PC load.
PCWriteCond  out  1  PC load if ALU Zero=1 (beq).
PCWriteCondNe  out  1  PC load if ALU Zero=0 (bne).
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
MemRead  out  1  memory read strobe.
MemWrite  out  1  memory write strobe.
IRWrite  out  1  instruction register load.
MemtoReg  out  1  register write-data select: 1 = ALUOut, 0 = MDR.
RegDst  out  1  destination select: 1 = rd, 0 = rt.
RegWrite  out  1  register file write enable.
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs register A.
ALUSrcB  out  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded, 11 = and.
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
instr_done  out  1  one-cycle pulse in the last cycle of every instruction.
state_dbg  out  STATE_W  current state code, for debug.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset). While reset=1: state=FETCH and all outputs are 0, including the FETCH Mealy terms.
- State codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11, TRAP=12 (TRAP exists only with the optional feature).
- Outputs are Moore, decoded from the state. The exceptions are PCWrite, IRWrite and instr_done in the memory states, which are additionally gated by mem_ready (Mealy).
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; PCWrite=IRWrite=mem_ready.
  - Next state: DECODE if mem_ready, else FETCH.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target).
  - Next state by opcode: 000000→EXEC_R; 001000 or 001100→EXEC_I; 100011 or 101011→MEM_ADDR; 000100 or 000101→BRANCH; 000010→JUMP.
  - Other opcodes → FETCH (executed as a NOP; instr_done pulses in DECODE).
- MEM_ADDR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: MEM_RD if opcode was lw, MEM_WR if sw. The opcode class is latched in DECODE.
- MEM_RD:
  - Outputs: MemRead=1, IorD=1.
  - Next state: MEM_WB on mem_ready, else hold.
- MEM_WB:
  - Outputs: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1.
  - Next state: FETCH.
- MEM_WR:
  - Outputs: MemWrite=1, IorD=1, instr_done=mem_ready.
  - Next state: FETCH on mem_ready, else hold. MemWrite stays high for every stall cycle.
- EXEC_R:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next state: R_WB.
- R_WB:
  - Outputs: RegDst=1, MemtoReg=1, RegWrite=1, instr_done=1.
  - Next state: FETCH.
- EXEC_I:
  - Outputs: ALUSrcA=1, ALUSrcB=10; ALUOp=00 for addi, 11 for andi.
  - Next state: I_WB.
- I_WB:
  - Outputs: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01; PCWriteCond=1 for beq or PCWriteCondNe=1 for bne; instr_done=1.
  - Next state: FETCH.
- JUMP:
  - Outputs: PCSource=10, PCWrite=1, instr_done=1.
  - Next state: FETCH.
- Latency with mem_ready=1 throughout: lw 5, sw 4, R/addi/andi 4, beq/bne 3, j 3 cycles. Each memory stall cycle adds 1.
- Opcode class and the andi/bne/lw flags are registered in DECODE, so later states ignore changes on opcode.
- Reset asserted mid-instruction aborts it immediately. No partial write occurs after reset assertion. After release, the first edge begins FETCH.
- mem_ready asserted outside FETCH/MEM_RD/MEM_WR is ignored.

Optional Feature:
MC_ILLEGAL_TRAP_EN.
- Defined: an unlisted opcode in DECODE goes to TRAP. TRAP drives all outputs 0, asserts illegal_op=1 (an extra output port) and holds until reset. instr_done does not pulse.
- Undefined: unlisted opcodes complete as a NOP (DECODE→FETCH). There is no illegal_op port and no TRAP state.

Decomposition:
- Shared package mc_pkg holds:
  - state codes;
  - opcode constants (OP_RTYPE, OP_ADDI, OP_ANDI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_J);
  - ALUOp, ALUSrcB and PCSource encodings.
- One natural sub-module, mc_output_decode: combinational state+flags+mem_ready → control vector. The FSM register and next-state logic stay in the top module.

Test Plan:
- Reset pulse mid-MEM_WR (MemWrite=1) → outputs 0 immediately and asynchronously; state_dbg=0 after release; no MemWrite afterwards.
- lw (100011), mem_ready=1 → states 0,1,2,3,4; RegWrite=1 with MemtoReg=0, RegDst=0 in cycle 5; instr_done pulses once.
- sw with mem_ready low for 3 cycles in MEM_WR → MemWrite high 4 cycles; instr_done only in the ready cycle; 7 cycles total.
- beq then bne → 3 cycles each; PCWriteCond=1 only for beq, PCWriteCondNe=1 only for bne; ALUOp=01, PCSource=01.
- R-type then andi → EXEC_R ALUOp=10, RegDst=1; EXEC_I ALUOp=11, ALUSrcB=10; MemtoReg=1 at both writebacks.
- Opcode 111111 → NOP back to FETCH in 2 cycles (feature off); TRAP with illegal_op=1 held for 10 cycles (feature on); opcode toggled after DECODE → no effect.
